// File: rtl/pll_mgr_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_mgr_pkg;

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_FAIL      = 2'd3
    } pll_state_e;

    localparam int RETRY_W = 4;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_ch.sv
// One supervised PLL: lock synchroniser, debounce/timeout counters and the
// reset/retry FSM. All outputs are registered.
module pll_lock_ch
    import pll_mgr_pkg::*;
#(
    parameter int RST_HOLD_CYC     = 250,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 25000,
    parameter int MAX_RETRY        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       sw_restart_i,
    output logic       pll_rst_o,
    output logic       pll_ok_o,
    output logic       pll_fail_o,
    output logic       lost_lock_o,
    output pll_state_e state_o
);

    localparam int HOLD_W = max(1, $clog2(RST_HOLD_CYC + 1));
    localparam int CNT_W  = max(1, $clog2(LOCK_TIMEOUT_CYC + 1));

    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [HOLD_W-1:0]  HOLD_SAT    = '1;
    localparam logic [CNT_W-1:0]   CNT_SAT     = '1;
    localparam logic [RETRY_W-1:0] RETRY_SAT   = '1;

    logic [1:0]         r_sync;
    logic               w_lock_s;
    pll_state_e         r_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]   r_stable_cnt;
    logic [CNT_W-1:0]   r_to_cnt;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic               r_pll_rst;
    logic               r_ok;
    logic               r_fail;
    logic               r_lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pll_lock_i};
        end
    end

    assign w_lock_s = r_sync[1];

    // sw_restart_i is a one-cycle strobe; it overrides every state transition
    // and silently restarts the channel (no lost_lock pulse, budget refilled).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RESET;
            r_hold_cnt   <= '0;
            r_stable_cnt <= '0;
            r_to_cnt     <= '0;
            r_retry_cnt  <= '0;
            r_pll_rst    <= 1'b1;
            r_ok         <= 1'b0;
            r_fail       <= 1'b0;
            r_lost       <= 1'b0;
        end else begin
            r_lost <= 1'b0;
            if (sw_restart_i) begin
                r_state      <= ST_RESET;
                r_hold_cnt   <= '0;
                r_stable_cnt <= '0;
                r_to_cnt     <= '0;
                r_retry_cnt  <= '0;
                r_pll_rst    <= 1'b1;
                r_ok         <= 1'b0;
                r_fail       <= 1'b0;
            end else begin
                case (r_state)
                    ST_RESET: begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_state      <= ST_WAIT_LOCK;
                            r_hold_cnt   <= '0;
                            r_stable_cnt <= '0;
                            r_to_cnt     <= '0;
                            r_pll_rst    <= 1'b0;
                        end else if (r_hold_cnt != HOLD_SAT) begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (w_lock_s && (r_stable_cnt == STABLE_LAST)) begin
                            r_state     <= ST_LOCKED;
                            r_retry_cnt <= '0;
                            r_ok        <= 1'b1;
                        end else if (r_to_cnt == TO_LAST) begin
                            r_pll_rst <= 1'b1;
                            if (r_retry_cnt == RETRY_MAX) begin
                                r_state <= ST_FAIL;
                                r_fail  <= 1'b1;
                            end else begin
                                r_state    <= ST_RESET;
                                r_hold_cnt <= '0;
                                if (r_retry_cnt != RETRY_SAT) begin
                                    r_retry_cnt <= r_retry_cnt + 1'b1;
                                end
                            end
                        end else begin
                            if (r_to_cnt != CNT_SAT) begin
                                r_to_cnt <= r_to_cnt + 1'b1;
                            end
                            if (!w_lock_s) begin
                                r_stable_cnt <= '0;
                            end else if (r_stable_cnt != CNT_SAT) begin
                                r_stable_cnt <= r_stable_cnt + 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_lock_s) begin
                            r_state    <= ST_RESET;
                            r_hold_cnt <= '0;
                            r_pll_rst  <= 1'b1;
                            r_ok       <= 1'b0;
                            r_lost     <= 1'b1;
                        end
                    end
                    ST_FAIL: begin
                        r_pll_rst <= 1'b1;
                        r_fail    <= 1'b1;
                    end
                    default: begin
                        r_state   <= ST_RESET;
                        r_pll_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign pll_rst_o   = r_pll_rst;
    assign pll_ok_o    = r_ok;
    assign pll_fail_o  = r_fail;
    assign lost_lock_o = r_lost;
    assign state_o     = r_state;

endmodule

// File: rtl/pll_lock_mgr.sv
// Lock supervisor for up to four PLLs on a shared reference clock; one
// independent channel per PLL plus a registered all-locked flag.
module pll_lock_mgr
    import pll_mgr_pkg::*;
#(
    parameter int NUM_PLL          = 2,
    parameter int RST_HOLD_CYC     = 250,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 25000,
    parameter int MAX_RETRY        = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PLL-1:0]     pll_lock_i,
    input  logic [NUM_PLL-1:0]     sw_restart_i,
    output logic [NUM_PLL-1:0]     pll_rst_o,
    output logic [NUM_PLL-1:0]     pll_ok_o,
    output logic [NUM_PLL-1:0]     pll_fail_o,
    output logic [NUM_PLL-1:0]     lost_lock_o,
    output logic                   all_ok_o,
    output logic [2*NUM_PLL-1:0]   dbg_state_o
);

    pll_state_e w_state [NUM_PLL];
    logic       r_all_ok;

    for (genvar g = 0; g < NUM_PLL; g++) begin : g_ch
        pll_lock_ch #(
            .RST_HOLD_CYC     (RST_HOLD_CYC),
            .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
            .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
            .MAX_RETRY        (MAX_RETRY)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .pll_lock_i   (pll_lock_i[g]),
            .sw_restart_i (sw_restart_i[g]),
            .pll_rst_o    (pll_rst_o[g]),
            .pll_ok_o     (pll_ok_o[g]),
            .pll_fail_o   (pll_fail_o[g]),
            .lost_lock_o  (lost_lock_o[g]),
            .state_o      (w_state[g])
        );
        assign dbg_state_o[2*g +: 2] = w_state[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_ok <= 1'b0;
        end else begin
            r_all_ok <= &pll_ok_o;
        end
    end

    assign all_ok_o = r_all_ok;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Directed bench for pll_lock_mgr: expected output snapshots keyed by cycle
// are queued up front; a negedge monitor pops and compares them.
module tb_pll_lock_mgr;

    localparam int EW = 41;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pll_lock_i = 2'b00;
    logic [1:0] sw_restart_i = 2'b00;
    logic [1:0] pll_rst_o;
    logic [1:0] pll_ok_o;
    logic [1:0] pll_fail_o;
    logic [1:0] lost_lock_o;
    logic       all_ok_o;
    logic [3:0] dbg_state_o;

    int tcyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];

    pll_lock_mgr #(
        .NUM_PLL          (2),
        .RST_HOLD_CYC     (8),
        .LOCK_STABLE_CYC  (16),
        .LOCK_TIMEOUT_CYC (40),
        .MAX_RETRY        (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock_i   (pll_lock_i),
        .sw_restart_i (sw_restart_i),
        .pll_rst_o    (pll_rst_o),
        .pll_ok_o     (pll_ok_o),
        .pll_fail_o   (pll_fail_o),
        .lost_lock_o  (lost_lock_o),
        .all_ok_o     (all_ok_o),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    // expected snapshot = {rst, ok, fail, lost, all}
    task automatic exp_at(input int cyc, input string nm, input logic [1:0] r,
                          input logic [1:0] o, input logic [1:0] f,
                          input logic [1:0] l, input logic a);
        exp_q.push_back({32'(cyc), r, o, f, l, a});
        name_q.push_back(nm);
    endtask

    task automatic at_cyc(input int n);
        wait (tcyc >= n);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [8:0]    obs;
        logic [EW-1:0] ent;
        string         nm;
        obs = {pll_rst_o, pll_ok_o, pll_fail_o, lost_lock_o, all_ok_o};
        while (exp_q.size() > 0 && int'(exp_q[0][40:9]) <= tcyc) begin
            ent = exp_q.pop_front();
            nm  = name_q.pop_front();
            n_cmp++;
            if (int'(ent[40:9]) != tcyc) begin
                n_fail++;
                $display("FAIL %s: slot for cycle %0d missed (now %0d)", nm, ent[40:9], tcyc);
            end else if (obs !== ent[8:0]) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got rst=%b ok=%b fail=%b lost=%b all=%b, want rst=%b ok=%b fail=%b lost=%b all=%b",
                         nm, tcyc, obs[8:7], obs[6:5], obs[4:3], obs[2:1], obs[0],
                         ent[8:7], ent[6:5], ent[4:3], ent[2:1], ent[0]);
            end
        end
    end

    // expectations (cycle n = n-th rising edge; rst_n released after edge 3)
    initial begin
        exp_at(2,   "reset_state",       2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        exp_at(10,  "rst_hold_last",     2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        exp_at(11,  "rst_release",       2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        exp_at(40,  "not_ok_yet",        2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        exp_at(41,  "ok_rise",           2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        exp_at(42,  "all_ok_rise",       2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        exp_at(55,  "loss_sync_delay",   2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        exp_at(56,  "lost_pulse",        2'b01, 2'b10, 2'b00, 2'b01, 1'b1);
        exp_at(57,  "lost_pulse_end",    2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(63,  "relock_rst_hold",   2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(64,  "relock_rst_rel",    2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(86,  "glitch_no_early",   2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(96,  "glitch_not_yet",    2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(97,  "glitch_ok_rise",    2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        exp_at(98,  "glitch_all_ok",     2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        exp_at(106, "ch1_lost_pulse",    2'b10, 2'b01, 2'b00, 2'b10, 1'b1);
        exp_at(107, "ch1_lost_end",      2'b10, 2'b01, 2'b00, 2'b00, 1'b0);
        exp_at(114, "ch1_rst_rel",       2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        exp_at(133, "restart_wins",      2'b10, 2'b01, 2'b00, 2'b00, 1'b0);
        exp_at(134, "restart_no_lost",   2'b10, 2'b01, 2'b00, 2'b00, 1'b0);
        exp_at(141, "restart_rst_rel",   2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        exp_at(156, "restart_not_ok",    2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        exp_at(157, "restart_ok",        2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        exp_at(158, "restart_all_ok",    2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
        exp_at(166, "to_lost_pulse",     2'b01, 2'b10, 2'b00, 2'b01, 1'b1);
        exp_at(174, "to_pulse1_end",     2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(213, "to_before_first",   2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(214, "to_pulse2_start",   2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(222, "to_pulse2_end",     2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(262, "to_pulse3_start",   2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(270, "to_pulse3_end",     2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(309, "to_before_fail",    2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(310, "fail_enter",        2'b01, 2'b10, 2'b01, 2'b00, 1'b0);
        exp_at(323, "fail_parked",       2'b01, 2'b10, 2'b01, 2'b00, 1'b0);
        exp_at(329, "fail_restart",      2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(337, "fail_restart_rel",  2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(377, "budget_retry1",     2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(472, "budget_before_fail",2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(473, "budget_fail",       2'b01, 2'b10, 2'b01, 2'b00, 1'b0);
        exp_at(479, "second_restart",    2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(487, "second_rst_rel",    2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
        exp_at(498, "async_reset",       2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        exp_at(507, "rerun_rst_hold",    2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        exp_at(508, "rerun_rst_rel",     2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        exp_at(523, "rerun_not_ok",      2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        exp_at(524, "rerun_ch1_ok",      2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
    end

    // driver
    initial begin
        at_cyc(3);   rst_n = 1'b1;
        at_cyc(23);  pll_lock_i = 2'b11;
        at_cyc(53);  pll_lock_i[0] = 1'b0;
        at_cyc(68);  pll_lock_i[0] = 1'b1;
        at_cyc(78);  pll_lock_i[0] = 1'b0;
        at_cyc(79);  pll_lock_i[0] = 1'b1;
        at_cyc(103); pll_lock_i[1] = 1'b0;
        at_cyc(115); pll_lock_i[1] = 1'b1;
        at_cyc(132); sw_restart_i = 2'b10;
        at_cyc(133); sw_restart_i = 2'b00;
        at_cyc(163); pll_lock_i[0] = 1'b0;
        at_cyc(328); sw_restart_i = 2'b01;
        at_cyc(329); sw_restart_i = 2'b00;
        at_cyc(478); sw_restart_i = 2'b01;
        at_cyc(479); sw_restart_i = 2'b00;
        at_cyc(498); rst_n = 1'b0;
        at_cyc(500); rst_n = 1'b1;
        at_cyc(530);
        while (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: never compared (cycle %0d)", name_q[0], exp_q[0][40:9]);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_mgr.md
# pll_lock_mgr

Parametrised lock supervisor for up to four PLL primitives sharing one free-running reference clock. Per channel it drives the PLL reset, synchronises and debounces the raw lock output, and retries on lock timeout. It also detects loss of lock and raises per-channel ok/fail status plus a global all-locked flag. It sits between the PLL wrapper instances and the board-level reset generator; downstream domain resets release from `pll_ok_o`/`all_ok_o`.

## Interface
- `NUM_PLL`, 2: number of supervised PLLs, 1..4.
- `RST_HOLD_CYC`, 250: cycles `pll_rst_o` is held high per attempt (10 us at 25 MHz); ≥1.
- `LOCK_STABLE_CYC`, 1024: consecutive synchronised-high lock cycles required to declare lock; ≥1.
- `LOCK_TIMEOUT_CYC`, 25000: maximum cycles in WAIT_LOCK per attempt; must exceed `LOCK_STABLE_CYC`.
- `MAX_RETRY`, 3: extra attempts after the first timeout before FAIL; 0..15.
- `clk` input 1: free-running reference clock (board 25 MHz oscillator, not a PLL output).
- `rst_n` input 1: reset, **asynchronous, active-low**.
- `pll_lock_i` input NUM_PLL: raw PLL lock signals, asynchronous to `clk`.
- `sw_restart_i` input NUM_PLL: per-channel single-cycle restart request, synchronous to `clk`.
- `pll_rst_o` output NUM_PLL: active-high reset to each PLL `rst` pin.
- `pll_ok_o` output NUM_PLL: channel in LOCKED.
- `pll_fail_o` output NUM_PLL: channel in FAIL.
- `lost_lock_o` output NUM_PLL: one-cycle pulse on LOCKED→RESET due to lock loss.
- `all_ok_o` output 1: registered AND of all `pll_ok_o`.

## Operation
- Per channel: a 2-flop synchroniser on `pll_lock_i[n]` produces `lock_s`. All decisions use `lock_s`.
- Per-channel FSM states are RESET, WAIT_LOCK, LOCKED, FAIL.
- RESET: `pll_rst_o`=1. `hold_cnt` counts 0..RST_HOLD_CYC-1, then moves to WAIT_LOCK and clears `stable_cnt` and `to_cnt`.
- WAIT_LOCK: `pll_rst_o`=0. `to_cnt` increments every cycle. `stable_cnt` increments while `lock_s`=1 and clears to 0 on `lock_s`=0.
  - If `lock_s`=1 and `stable_cnt`==LOCK_STABLE_CYC-1, go to LOCKED and clear `retry_cnt`.
  - Otherwise, if `to_cnt`==LOCK_TIMEOUT_CYC-1, this is a timeout. If `retry_cnt`==MAX_RETRY, go to FAIL; else increment `retry_cnt` and go to RESET.
- LOCKED: `pll_ok_o`=1. If `lock_s`=0, pulse `lost_lock_o` for 1 cycle and go to RESET. `retry_cnt` stays 0, so a fresh retry budget applies.
- FAIL: `pll_fail_o`=1 and `pll_rst_o`=1, so a failed PLL stays parked in reset. The only exits are `sw_restart_i` or `rst_n`.
- `sw_restart_i[n]`=1 in any state: next state is RESET, all counters are cleared, and no `lost_lock_o` pulse is generated.
- Priority, highest first: `sw_restart_i`, then lock-stable completion, then timeout, then lock loss.
- Channels are fully independent. One channel's FAIL or relock does not disturb the others.
- Counter widths:
  - `hold_cnt`: $clog2(RST_HOLD_CYC+1).
  - `stable_cnt`, `to_cnt`: $clog2(LOCK_TIMEOUT_CYC+1).
  - `retry_cnt`: 4 bits.
  - Counters saturate and never wrap.

## Timing
- Values while `rst_n`=0:
  - All FSMs are in RESET with counters 0.
  - `pll_rst_o`=all 1.
  - `pll_ok_o`, `pll_fail_o`, `lost_lock_o`, `all_ok_o` = 0.
  - Synchroniser flops = 0.
- After `rst_n` rises, `pll_rst_o[n]` falls after exactly RST_HOLD_CYC rising edges.
- `pll_lock_i` to `lock_s` latency: 2 cycles.
- `pll_ok_o` rises LOCK_STABLE_CYC cycles after the first `lock_s`=1 cycle of an unbroken run.
  - Worst case from the raw lock edge: LOCK_STABLE_CYC+2 cycles.
- Lock loss: `lost_lock_o` and the fall of `pll_ok_o` occur 3 edges after the raw lock falls (2 sync + 1 FSM). `pll_rst_o` rises on the same edge.
- `all_ok_o` lags the last `pll_ok_o` change by 1 cycle.
- All outputs are registered; none are combinational from inputs.
- Mid-operation `rst_n` assertion clears all state asynchronously and raises `pll_rst_o` immediately.

## Structure
- Shared package `pll_mgr_pkg`:
  - FSM state encoding (RESET=2'd0, WAIT_LOCK=2'd1, LOCKED=2'd2, FAIL=2'd3).
  - Retry counter width constant (4).
  - A `max` helper for counter sizing.
- Sub-module `pll_lock_ch`: one channel with its synchroniser, counters and FSM. It is instantiated NUM_PLL times by a generate loop.
- The top level only instantiates channels and registers `all_ok_o`.

## Test plan
- Power-up, NUM_PLL=2, RST_HOLD_CYC=8, LOCK_STABLE_CYC=16.
  - Stimulus: `rst_n` released at cycle 0; `pll_lock_i`=2'b11 from cycle 20.
  - Required: `pll_rst_o`=2'b00 at cycle 8; `pll_ok_o`=2'b11 at cycle 38; `all_ok_o` at cycle 39.
- Glitchy lock.
  - Stimulus: lock high 10 cycles, low 1 cycle, then high.
  - Required: `stable_cnt` restarts; `pll_ok_o` asserts only 16 cycles after the final rise reaches `lock_s`.
- Timeout/retry, LOCK_TIMEOUT_CYC=40, MAX_RETRY=2.
  - Stimulus: lock held low.
  - Required: exactly 3 RESET pulses on `pll_rst_o[0]`; then `pll_fail_o[0]`=1 with `pll_rst_o[0]`=1 held; channel 1 unaffected.
- Loss of lock.
  - Stimulus: lock drops in LOCKED.
  - Required: `lost_lock_o` 1-cycle pulse 3 edges later; `pll_rst_o` high for 8 cycles; relock restores `pll_ok_o`.
- Restart and reset priority.
  - Stimulus 1: `sw_restart_i[0]` in FAIL. Required: RESET with retry budget fully restored.
  - Stimulus 2: `sw_restart_i` asserted on the same edge as stable completion. Required: RESET wins, no `lost_lock_o`.
  - Stimulus 3: `rst_n` pulsed low mid-WAIT_LOCK. Required: all outputs return to reset values asynchronously.
